// File: rtl/glyph_row_fetcher.sv
// glyph_row_fetcher
// Initiator side of the character ROM read interface. Takes a glyph/row
// request, drives the ROM address offsets and read-enable strobe with one
// cycle of address setup and one cycle of hold, captures the returned byte,
// then serializes it MSB-first as a pixel stream paced by pixelEn.
//
// Optional build macro: CURSOR_INVERT_EN
//   defined   -> extra input port `invert`, latched with the request; the
//                serialized pixel is XORed with it (block cursor / reverse video)
//   undefined -> no `invert` port; pixels come straight from the glyph byte
module glyph_row_fetcher #(
  parameter int SCALE = 1,   // pixel ticks per glyph bit, 1..4
  parameter int ROWS  = 16   // glyph rows per character
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] glyphSel,
  input  logic [3:0] rowSel,
  input  logic       pixelEn,
`ifdef CURSOR_INVERT_EN
  input  logic       invert,
`endif
  input  logic [7:0] romByte,
  output logic       romEnable,
  output logic [2:0] highAddrOffset,
  output logic [3:0] lowAddrOffset,
  output logic       ready,
  output logic       pixelValid,
  output logic       pixelOut,
  output logic       done
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_STROBE  = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_SHIFT   = 3'd4;

  localparam logic [1:0] SCALE_LAST = 2'(SCALE - 1);
  localparam logic [3:0] ROW_LAST   = 4'(ROWS - 1);
  localparam logic [4:0] ROW_COUNT  = 5'(ROWS);

  logic [2:0] state_reg, state_next;
  logic [1:0] glyph_reg, glyph_next;
  logic [3:0] row_reg, row_next;
  logic [7:0] shift_reg, shift_next;
  logic [1:0] scale_cnt_reg, scale_cnt_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic       done_reg, done_next;
`ifdef CURSOR_INVERT_EN
  logic       inv_reg, inv_next;
`endif

  logic [3:0] row_clamped;
  logic [7:0] shift_left;
  logic       accept;
  logic       bit_end;
  logic       row_end;
  logic       pixel_bit;

  // Rows past the end of the glyph read the last real row instead of
  // wrapping into the neighbouring character.
  assign row_clamped = ({1'b0, rowSel} >= ROW_COUNT) ? ROW_LAST : rowSel;

  // A start coinciding with the done pulse is dropped so a row that just
  // finished cannot be chained without the caller seeing done first.
  assign accept  = (state_reg == ST_IDLE) && start && !done_reg;
  assign bit_end = pixelEn && (scale_cnt_reg == SCALE_LAST);
  assign row_end = bit_end && (bit_cnt_reg == 3'd7);

  // Serializer shift network: each bit moves one place toward the MSB.
  assign shift_left[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_shift
      assign shift_left[gi] = shift_reg[gi-1];
    end
  endgenerate

`ifdef CURSOR_INVERT_EN
  assign pixel_bit = shift_reg[7] ^ inv_reg;
`else
  assign pixel_bit = shift_reg[7];
`endif

  // Next-state and datapath update for the fetch/serialize sequence.
  always_comb begin
    state_next     = state_reg;
    glyph_next     = glyph_reg;
    row_next       = row_reg;
    shift_next     = shift_reg;
    scale_cnt_next = scale_cnt_reg;
    bit_cnt_next   = bit_cnt_reg;
    done_next      = 1'b0;
`ifdef CURSOR_INVERT_EN
    inv_next       = inv_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          glyph_next     = glyphSel;
          row_next       = row_clamped;
          scale_cnt_next = 2'd0;
          bit_cnt_next   = 3'd0;
`ifdef CURSOR_INVERT_EN
          inv_next       = invert;
`endif
          state_next     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        // Address already on the bus; give the ROM one cycle of setup.
        state_next = ST_STROBE;
      end
      ST_STROBE: begin
        state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // ROM controller registered its data on the strobe edge.
        shift_next     = romByte;
        scale_cnt_next = 2'd0;
        bit_cnt_next   = 3'd0;
        state_next     = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (pixelEn) begin
          if (bit_end) begin
            scale_cnt_next = 2'd0;
            shift_next     = shift_left;
            bit_cnt_next   = bit_cnt_reg + 3'd1;
            if (row_end) begin
              done_next  = 1'b1;
              state_next = ST_IDLE;
            end
          end else begin
            scale_cnt_next = scale_cnt_reg + 2'd1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset returns everything to idle at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      glyph_reg     <= 2'd0;
      row_reg       <= 4'd0;
      shift_reg     <= 8'd0;
      scale_cnt_reg <= 2'd0;
      bit_cnt_reg   <= 3'd0;
      done_reg      <= 1'b0;
`ifdef CURSOR_INVERT_EN
      inv_reg       <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      glyph_reg     <= glyph_next;
      row_reg       <= row_next;
      shift_reg     <= shift_next;
      scale_cnt_reg <= scale_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      done_reg      <= done_next;
`ifdef CURSOR_INVERT_EN
      inv_reg       <= inv_next;
`endif
    end
  end

  // Outputs decode straight from registered state, so an asynchronous reset
  // drops romEnable and raises the read inhibit without waiting for a clock.
  always_comb begin
    romEnable      = (state_reg == ST_STROBE);
    highAddrOffset = (state_reg == ST_IDLE) ? 3'b100 : {1'b0, glyph_reg};
    lowAddrOffset  = row_reg;
    ready          = (state_reg == ST_IDLE);
    pixelValid     = (state_reg == ST_SHIFT);
    pixelOut       = (state_reg == ST_SHIFT) && pixel_bit;
    done           = done_reg;
  end

endmodule
